fp_norm_round: RTL and testbench

- Normalization and rounding stage directly downstream of the 48-bit leading-zero detector in the single-precision FP datapath.
- Takes the raw 48-bit significand product, its leading-zero count from the detector, a wide biased exponent and the sign.
- Left-normalizes, rounds to nearest-even to 24 bits, adjusts the exponent, and emits a packed IEEE-754 single with status flags.
- Two-stage valid/ready pipeline.

---
 rtl/fp_norm_round.sv | 164 ++++++++++++++++
 tb/tb_fp_norm_round.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - normalize and round-to-nearest-even stage producing an IEEE-754 single
//
// Purpose: left-normalizes a 48-bit significand using a precomputed leading-zero
// count, rounds to 24 bits (RNE), adjusts the exponent and packs a single-precision
// result with zero/overflow/underflow/inexact flags. Two registered stages sharing
// one enable, so a stalled output freezes the whole pipe.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = ~out_valid | out_ready
//   sign_in             result sign
//   exp_in [EW-1:0]     signed biased exponent of data_in bit MW-1
//   data_in [MW-1:0]    unnormalized significand
//   lzd_in [LZW-1:0]    leading-zero count of data_in (>= MW means zero)
//   out_valid/out_ready output handshake
//   data_out [31:0]     {sign, exp[7:0], frac[22:0]}
//   zero_flag, ovf_flag, unf_flag, inexact_flag  status, qualified by out_valid
module fp_norm_round #(
  parameter int MW  = 48,
  parameter int LZW = 6,
  parameter int EW  = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           sign_in,
  input  logic [EW-1:0]  exp_in,
  input  logic [MW-1:0]  data_in,
  input  logic [LZW-1:0] lzd_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    data_out,
  output logic           zero_flag,
  output logic           ovf_flag,
  output logic           unf_flag,
  output logic           inexact_flag
);

  localparam logic signed [EW:0] EXP_MAX = (EW+1)'(255);
  localparam logic signed [EW:0] EXP_MIN = '0;

  logic w_en;

  // Stage 1 state
  logic                 r_v1;
  logic                 r_s1;
  logic                 r_z1;
  logic [MW-1:0]        r_norm;
  logic signed [EW:0]   r_e1;

  // Stage 2 state
  logic                 r_v2;
  logic [31:0]          r_data;
  logic                 r_zero;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 r_inex;

  // Stage 1 combinational
  logic [MW-1:0]        w_norm;
  logic signed [EW:0]   w_e1;
  logic                 w_z1;

  // Stage 2 combinational
  logic [23:0]          w_sig;
  logic                 w_g;
  logic                 w_st;
  logic                 w_rnd;
  logic [24:0]          w_sum;
  logic [22:0]          w_frac;
  logic signed [EW:0]   w_e2;
  logic [31:0]          w_data;
  logic                 w_zero;
  logic                 w_ovf;
  logic                 w_unf;
  logic                 w_inex;

  assign w_en     = ~r_v2 | out_ready;
  assign in_ready = w_en;

  // Shifting by MW or more yields all zeros, which is also what a zero input needs.
  assign w_norm = data_in << lzd_in;
  assign w_e1   = $signed({exp_in[EW-1], exp_in}) - $signed({{(EW+1-LZW){1'b0}}, lzd_in});
  assign w_z1   = ({1'b0, lzd_in} >= (LZW+1)'(MW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_s1   <= 1'b0;
      r_z1   <= 1'b0;
      r_norm <= '0;
      r_e1   <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1   <= sign_in;
        r_z1   <= w_z1;
        r_norm <= w_norm;
        r_e1   <= w_e1;
      end
    end
  end

  assign w_sig = r_norm[MW-1 -: 24];
  assign w_g   = r_norm[MW-25];
  assign w_st  = |r_norm[MW-26:0];
  assign w_rnd = w_g & (w_st | w_sig[0]);
  assign w_sum = {1'b0, w_sig} + {24'd0, w_rnd};

  // A carry out of the 24-bit significand only happens from all-ones, so the
  // renormalized fraction is zero and the exponent bumps by one.
  assign w_frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
  assign w_e2   = r_e1 + $signed({{EW{1'b0}}, w_sum[24]});

  always_comb begin
    w_data = {r_s1, w_e2[7:0], w_frac};
    w_zero = 1'b0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_inex = w_g | w_st;
    if (r_z1) begin
      w_data = {r_s1, 31'd0};
      w_zero = 1'b1;
      w_inex = 1'b0;
    end else if (w_e2 >= EXP_MAX) begin
      w_data = {r_s1, 8'hFF, 23'd0};
      w_ovf  = 1'b1;
      w_inex = 1'b1;
    end else if (w_e2 <= EXP_MIN) begin
      w_data = {r_s1, 31'd0};
      w_unf  = 1'b1;
      w_inex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_data <= '0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_inex <= 1'b0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data <= w_data;
        r_zero <= w_zero;
        r_ovf  <= w_ovf;
        r_unf  <= w_unf;
        r_inex <= w_inex;
      end
    end
  end

  assign out_valid    = r_v2;
  assign data_out     = r_data;
  assign zero_flag    = r_zero & r_v2;
  assign ovf_flag     = r_ovf  & r_v2;
  assign unf_flag     = r_unf  & r_v2;
  assign inexact_flag = r_inex & r_v2;

endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - self-checking bench for fp_norm_round
module tb_fp_norm_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [47:0] data_in;
  logic [5:0]  lzd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        zero_flag;
  logic        ovf_flag;
  logic        unf_flag;
  logic        inexact_flag;

  fp_norm_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign_in      (sign_in),
    .exp_in       (exp_in),
    .data_in      (data_in),
    .lzd_in       (lzd_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .zero_flag    (zero_flag),
    .ovf_flag     (ovf_flag),
    .unf_flag     (unf_flag),
    .inexact_flag (inexact_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {zero, ovf, unf, inexact}
  typedef struct {
    logic        sgn;
    logic [9:0]  exp;
    logic [47:0] data;
    logic [5:0]  lzd;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[16];
  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] flags();
    return {zero_flag, ovf_flag, unf_flag, inexact_flag};
  endfunction

  task automatic drive(input vec_t v);
    sign_in = v.sgn;
    exp_in  = v.exp;
    data_in = v.data;
    lzd_in  = v.lzd;
  endtask

  task automatic run_vec(input int i);
    @(posedge clk); #1;
    drive(vecs[i]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_lat_early", i), 64'(out_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d_data", i), 64'(data_out), 64'(vecs[i].exp_data));
    chk($sformatf("v%0d_flags", i), 64'(flags()), 64'(vecs[i].exp_flags));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign_in   = 1'b0;
    exp_in    = '0;
    data_in   = '0;
    lzd_in    = '0;

    vecs[0]  = '{1'b0, 10'd127, 48'h800000_000000, 6'd0,  32'h3F800000, 4'b0000};
    vecs[1]  = '{1'b0, 10'd127, 48'h800001_800000, 6'd0,  32'h3F800002, 4'b0001};
    vecs[2]  = '{1'b0, 10'd127, 48'h800000_800000, 6'd0,  32'h3F800000, 4'b0001};
    vecs[3]  = '{1'b0, 10'd127, 48'hFFFFFF_800000, 6'd0,  32'h40000000, 4'b0001};
    vecs[4]  = '{1'b0, 10'd254, 48'hFFFFFF_800000, 6'd0,  32'h7F800000, 4'b0101};
    vecs[5]  = '{1'b1, 10'd127, 48'h000000_000000, 6'd48, 32'h80000000, 4'b1000};
    vecs[6]  = '{1'b0, 10'd3,   48'h040000_000000, 6'd5,  32'h00000000, 4'b0011};
    vecs[7]  = '{1'b0, 10'd127, 48'h800000_400001, 6'd0,  32'h3F800000, 4'b0001};
    vecs[8]  = '{1'b0, 10'd127, 48'h800000_C00000, 6'd0,  32'h3F800001, 4'b0001};
    vecs[9]  = '{1'b1, 10'd150, 48'h000001_000000, 6'd23, 32'hBF800000, 4'b0000};
    vecs[10] = '{1'b0, 10'd254, 48'h800000_000000, 6'd0,  32'h7F000000, 4'b0000};
    vecs[11] = '{1'b0, 10'd255, 48'h800000_000000, 6'd0,  32'h7F800000, 4'b0101};
    vecs[12] = '{1'b0, 10'd1,   48'h800000_000000, 6'd0,  32'h00800000, 4'b0000};
    vecs[13] = '{1'b1, 10'd0,   48'h800000_000000, 6'd0,  32'h80000000, 4'b0011};
    vecs[14] = '{1'b0, 10'h3FD, 48'hC00000_000000, 6'd0,  32'h00000000, 4'b0011};
    vecs[15] = '{1'b0, 10'd127, 48'h123456_789ABC, 6'd50, 32'h00000000, 4'b1000};

    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_flags", 64'(flags()), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Backpressure: four beats, downstream stalled for the first six cycles.
    begin
      int sent;
      int got;
      int stall_cycles;
      logic [31:0] held;
      logic        have_held;
      sent = 0;
      got = 0;
      stall_cycles = 0;
      have_held = 1'b0;
      held = '0;
      for (int c = 0; c < 40 && got < 4; c++) begin
        @(posedge clk); #1;
        out_ready = (c >= 6);
        in_valid  = (sent < 4);
        if (sent < 4) drive(vecs[sent]);
        @(negedge clk);
        if (out_valid && !out_ready) begin
          stall_cycles++;
          chk("bp_in_ready_low", 64'(in_ready), 64'd0);
          if (have_held) chk("bp_data_stable", 64'(data_out), 64'(held));
          held = data_out;
          have_held = 1'b1;
        end
        if (in_valid && in_ready) sent++;
        if (out_valid && out_ready) begin
          chk($sformatf("bp_out%0d_data", got), 64'(data_out), 64'(vecs[got].exp_data));
          chk($sformatf("bp_out%0d_flags", got), 64'(flags()), 64'(vecs[got].exp_flags));
          got++;
        end
      end
      chk("bp_all_out", 64'(got), 64'd4);
      chk("bp_stalled", 64'(stall_cycles >= 3), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("bp_no_dup", 64'(out_valid), 64'd0);
      end
    end

    // Reset with two beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(vecs[1]);
    @(posedge clk); #1;
    drive(vecs[3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rs_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_data_out", 64'(data_out), 64'd0);
    chk("rs_flags", 64'(flags()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("rs_nothing_emitted", 64'(seen), 64'd0);
    end
    run_vec(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
